// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared constants and FSM state encoding for the multiply/divide unit
//
// Purpose : default operand width, counter width, most-negative operand constant,
//           and the FSM state type used by multdiv_unit.
// Ports   : none (package).

package multdiv_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/multdiv_counter.sv
// rtl/multdiv_counter.sv - iteration counter for the multiply/divide unit
//
// Purpose : CNT_W-bit up-counter with synchronous clear and enable; flags the
//           final iteration when the count equals WIDTH-1.
// Ports   : clock    - rising-edge clock
//           reset    - synchronous active-high reset (count to 0)
//           clear    - synchronous clear, used on every operation start
//           enable   - count one iteration
//           terminal - high while count == WIDTH-1

module multdiv_counter #(
    parameter int WIDTH = multdiv_pkg::WIDTH,
    parameter int CNT_W = multdiv_pkg::CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - iterative signed multiply/divide unit for the execute stage
//
// Purpose : signed WIDTH-bit multiply (low half of product, overflow flag) and
//           signed truncating divide (quotient, divide-by-zero / MIN/-1 flag),
//           one iteration per clock over magnitudes, sign fixed at the end.
//           Optional macro MULTDIV_DIV0_FAST_EN: a divide by zero finishes the
//           cycle after its start instead of running all iterations.
// Ports   : clock          - rising-edge clock
//           reset          - synchronous active-high reset
//           data_operandA  - multiplicand / dividend, sampled on a start cycle
//           data_operandB  - multiplier / divisor, sampled on a start cycle
//           ctrl_MULT      - start multiply (wins over ctrl_DIV)
//           ctrl_DIV       - start divide
//           data_result    - low product half or quotient, held until next completion
//           data_exception - overflow / divide-by-zero / MIN/-1, held with data_result
//           data_resultRDY - one-cycle completion pulse
//           busy           - operation in flight or being started this cycle

module multdiv_unit #(
    parameter int WIDTH = multdiv_pkg::WIDTH,
    parameter int CNT_W = multdiv_pkg::CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    import multdiv_pkg::*;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    // Magnitude on WIDTH+1 bits so that |MIN| is representable without wrap.
    function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] ext;
        ext = {v[WIDTH-1], v};
        return v[WIDTH-1] ? (~ext + (WIDTH+1)'(1)) : ext;
    endfunction

    state_t state, state_next;

    logic start_mul, start_div, start, run, terminal, div0_start;
    logic [WIDTH:0] mag_a, mag_b;

    // mag holds |A| for a multiply and |B| for a divide.
    // acc: multiply -> {partial high (W+1), multiplier shifting out (W)}
    //      divide   -> {remainder (W+1), dividend shifting out / quotient in (W)}
    logic [WIDTH:0]     mag;
    logic [2*WIDTH:0]   acc, acc_next;
    logic               neg_r, div0_r, ovf_r;

    logic [WIDTH+1:0]   mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quot, quot_s;
    logic [WIDTH-1:0]   final_result;
    logic               final_exc;

    assign start_mul  = ctrl_MULT;
    assign start_div  = ctrl_DIV & ~ctrl_MULT;
    assign start      = ctrl_MULT | ctrl_DIV;
    assign div0_start = start_div & (data_operandB == '0);
    assign run        = (state == MUL) || (state == DIV);
    assign mag_a      = magnitude(data_operandA);
    assign mag_b      = magnitude(data_operandB);

    assign data_resultRDY = (state == DONE);
    assign busy           = run | ctrl_MULT | ctrl_DIV;

    multdiv_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (start),
        .enable   (run),
        .terminal (terminal)
    );

    // One iteration of the active operation.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH:WIDTH]} + (acc[0] ? {1'b0, mag} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {1'b0, mag};
        acc_next  = acc;
        if (state == MUL) begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end else if (state == DIV) begin
            // Borrow out means the divisor did not fit: restore.
            if (div_diff[WIDTH+1]) begin
                acc_next = {div_shift, acc[WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {div_diff[WIDTH:0], acc[WIDTH-2:0], 1'b1};
            end
        end
    end

    // Sign fix-up and exception flags, evaluated on the final iteration.
    always_comb begin
        prod   = acc_next[2*WIDTH-1:0];
        prod_s = neg_r ? (~prod + (2*WIDTH)'(1)) : prod;
        quot   = acc_next[WIDTH-1:0];
        quot_s = neg_r ? (~quot + WIDTH'(1)) : quot;
        if (state == MUL) begin
            final_result = prod_s[WIDTH-1:0];
            final_exc    = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
        end else if (div0_r) begin
            final_result = '0;
            final_exc    = 1'b1;
        end else begin
            final_result = quot_s;
            final_exc    = ovf_r;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (start_mul) begin
            state_next = MUL;
        end else if (start_div) begin
`ifdef MULTDIV_DIV0_FAST_EN
            state_next = div0_start ? DONE : DIV;
`else
            state_next = DIV;
`endif
        end else begin
            case (state)
                MUL, DIV: if (terminal) state_next = DONE;
                DONE:     state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc            <= '0;
            mag            <= '0;
            neg_r          <= 1'b0;
            div0_r         <= 1'b0;
            ovf_r          <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start) begin
            neg_r  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div0_r <= div0_start;
            ovf_r  <= start_div & (data_operandA == MIN_VAL) & (data_operandB == '1);
            if (start_mul) begin
                mag <= mag_a;
                acc <= {{(WIDTH+1){1'b0}}, mag_b[WIDTH-1:0]};
            end else begin
                mag <= mag_b;
                acc <= {{(WIDTH+1){1'b0}}, mag_a[WIDTH-1:0]};
            end
`ifdef MULTDIV_DIV0_FAST_EN
            if (div0_start) begin
                data_result    <= '0;
                data_exception <= 1'b1;
            end
`endif
        end else if (run) begin
            acc <= acc_next;
            if (terminal) begin
                data_result    <= final_result;
                data_exception <= final_exc;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - directed self-checking bench for multdiv_unit

module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA, data_operandB;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;

    int checks   = 0;
    int failures = 0;

`ifdef MULTDIV_DIV0_FAST_EN
    localparam int DIV0_LAT = 0;
`else
    localparam int DIV0_LAT = 32;
`endif

    always #5 clock = ~clock;

    multdiv_unit dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    // Called 1 time unit after a rising edge; returns 1 unit after start edge N.
    task automatic start_op(input logic m, input logic d, input logic [31:0] a,
                            input logic [31:0] b, output logic busy_start);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(negedge clock);
        busy_start = busy;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'hDEADBEEF;
        data_operandB = 32'h0BADF00D;
    endtask

    // cyc = number of edges after the start edge before RDY is seen; -1 on timeout.
    // Returns at the falling edge inside the RDY cycle.
    task automatic wait_rdy(output int cyc, output logic busy_ok);
        cyc     = -1;
        busy_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                cyc = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            @(posedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = '0; data_operandB = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++; if (data_result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", data_result); end
        checks++; if (data_exception !== 1'b0) begin failures++; $display("FAIL reset_exc got=%b exp=0", data_exception); end
        checks++; if (data_resultRDY !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", data_resultRDY); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(posedge clock); #1;
    endtask

    task automatic test_mult();
        logic [31:0] va [4] = '{32'd7, 32'h00010000, 32'h80000000, 32'hFFFFFFFB};
        logic [31:0] vb [4] = '{32'hFFFFFFFD, 32'h00010000, 32'd1, 32'hFFFFFFFA};
        logic [31:0] vr [4] = '{32'hFFFFFFEB, 32'h00000000, 32'h80000000, 32'h0000001E};
        logic        ve [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic bs, bok;
        int cyc;
        for (int i = 0; i < 4; i++) begin
            start_op(1'b1, 1'b0, va[i], vb[i], bs);
            wait_rdy(cyc, bok);
            checks++; if (cyc !== 32) begin failures++; $display("FAIL mult%0d_latency got=%0d exp=32", i, cyc); end
            checks++; if (data_result !== vr[i]) begin failures++; $display("FAIL mult%0d_result got=%h exp=%h", i, data_result, vr[i]); end
            checks++; if (data_exception !== ve[i]) begin failures++; $display("FAIL mult%0d_exc got=%b exp=%b", i, data_exception, ve[i]); end
            checks++; if (bs !== 1'b1 || bok !== 1'b1) begin failures++; $display("FAIL mult%0d_busy_run start=%b run=%b exp=1/1", i, bs, bok); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mult%0d_busy_done got=%b exp=0", i, busy); end
            @(posedge clock); @(negedge clock);
            checks++; if (data_resultRDY !== 1'b0) begin failures++; $display("FAIL mult%0d_rdy_width got=%b exp=0", i, data_resultRDY); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_div();
        logic [31:0] va [4] = '{32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd7};
        logic [31:0] vb [4] = '{32'd2, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFE};
        logic [31:0] vr [4] = '{32'hFFFFFFFD, 32'd14, 32'h80000000, 32'hFFFFFFFD};
        logic        ve [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic bs, bok;
        int cyc;
        for (int i = 0; i < 4; i++) begin
            start_op(1'b0, 1'b1, va[i], vb[i], bs);
            wait_rdy(cyc, bok);
            checks++; if (cyc !== 32) begin failures++; $display("FAIL div%0d_latency got=%0d exp=32", i, cyc); end
            checks++; if (data_result !== vr[i]) begin failures++; $display("FAIL div%0d_result got=%h exp=%h", i, data_result, vr[i]); end
            checks++; if (data_exception !== ve[i]) begin failures++; $display("FAIL div%0d_exc got=%b exp=%b", i, data_exception, ve[i]); end
            checks++; if (bs !== 1'b1 || bok !== 1'b1) begin failures++; $display("FAIL div%0d_busy_run start=%b run=%b exp=1/1", i, bs, bok); end
            @(posedge clock); @(negedge clock);
            checks++; if (data_resultRDY !== 1'b0) begin failures++; $display("FAIL div%0d_rdy_width got=%b exp=0", i, data_resultRDY); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_div_zero();
        logic bs, bok;
        int cyc;
        start_op(1'b0, 1'b1, 32'd5, 32'd0, bs);
        wait_rdy(cyc, bok);
        checks++; if (cyc !== DIV0_LAT) begin failures++; $display("FAIL div0_latency got=%0d exp=%0d", cyc, DIV0_LAT); end
        checks++; if (data_result !== 32'h0) begin failures++; $display("FAIL div0_result got=%h exp=0", data_result); end
        checks++; if (data_exception !== 1'b1) begin failures++; $display("FAIL div0_exc got=%b exp=1", data_exception); end
        checks++; if (bs !== 1'b1 || bok !== 1'b1) begin failures++; $display("FAIL div0_busy start=%b run=%b exp=1/1", bs, bok); end
        @(posedge clock); @(negedge clock);
        checks++; if (data_resultRDY !== 1'b0) begin failures++; $display("FAIL div0_rdy_width got=%b exp=0", data_resultRDY); end
        @(posedge clock); #1;
    endtask

    task automatic test_restart();
        logic bs, bok;
        int cyc;
        int early = 0;
        start_op(1'b1, 1'b0, 32'd3, 32'd4, bs);
        for (int i = 1; i < 10; i++) begin
            @(negedge clock);
            if (data_resultRDY) early++;
            @(posedge clock);
        end
        #1;
        data_operandA = 32'd100; data_operandB = 32'd7; ctrl_DIV = 1'b1;
        @(negedge clock);
        if (data_resultRDY) early++;
        @(posedge clock);
        #1 ctrl_DIV = 1'b0;
        wait_rdy(cyc, bok);
        checks++; if (early !== 0) begin failures++; $display("FAIL restart_early_rdy got=%0d exp=0", early); end
        checks++; if (cyc !== 32) begin failures++; $display("FAIL restart_latency got=%0d exp=32", cyc); end
        checks++; if (data_result !== 32'd14) begin failures++; $display("FAIL restart_result got=%h exp=0000000e", data_result); end
        checks++; if (data_exception !== 1'b0) begin failures++; $display("FAIL restart_exc got=%b exp=0", data_exception); end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid();
        logic bs, bok;
        int cyc;
        int seen = 0;
        start_op(1'b0, 1'b1, 32'd100, 32'd7, bs);
        repeat (19) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (data_result !== 32'h0) begin failures++; $display("FAIL rstmid_result got=%h exp=0", data_result); end
        for (int i = 0; i < 40; i++) begin
            if (data_resultRDY) seen++;
            @(negedge clock);
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rstmid_no_rdy got=%0d exp=0", seen); end
        @(posedge clock); #1;
        start_op(1'b1, 1'b0, 32'd2, 32'd2, bs);
        wait_rdy(cyc, bok);
        checks++; if (cyc !== 32) begin failures++; $display("FAIL rstmid_mult_latency got=%0d exp=32", cyc); end
        checks++; if (data_result !== 32'd4) begin failures++; $display("FAIL rstmid_mult_result got=%h exp=00000004", data_result); end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        logic bs, bok;
        int cyc;
        start_op(1'b1, 1'b0, 32'h7FFFFFFF, 32'd2, bs);
        wait_rdy(cyc, bok);
        checks++; if (data_result !== 32'hFFFFFFFE || data_exception !== 1'b1) begin
            failures++; $display("FAIL b2b_mult got=%h/%b exp=fffffffe/1", data_result, data_exception); end
        // New divide started in the RDY cycle (-100 / 7).
        data_operandA = 32'hFFFFFF9C; data_operandB = 32'd7; ctrl_DIV = 1'b1;
        @(posedge clock);
        #1 ctrl_DIV = 1'b0;
        @(negedge clock);
        checks++; if (data_result !== 32'hFFFFFFFE) begin failures++; $display("FAIL b2b_hold got=%h exp=fffffffe", data_result); end
        @(posedge clock);
        // One edge already consumed above, so RDY is 31 edges further on.
        wait_rdy(cyc, bok);
        checks++; if (cyc !== 31) begin failures++; $display("FAIL b2b_latency got=%0d exp=31", cyc); end
        checks++; if (data_result !== 32'hFFFFFFF2 || data_exception !== 1'b0) begin
            failures++; $display("FAIL b2b_div got=%h/%b exp=fffffff2/0", data_result, data_exception); end
        @(posedge clock); #1;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
